mem_arbiter: RTL and testbench

//  Shares one mem_system (cache + four_bank_mem) between an instruction-fetch port (I, read-only) and a data port (D).

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arbiter_watchdog.sv | 26 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the I/D memory arbiter: FSM states, port ids,
// memory op codes and the grant decision.
package mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_ABORT   = 2'd2,
        ST_ILLEGAL = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Round-robin falls back to "whoever was not granted last" only on a tie.
    function automatic port_t pick_port(input logic  i_req,
                                        input logic  d_req,
                                        input logic  fixed_prio,
                                        input port_t last_grant);
        if (d_req && (!i_req || fixed_prio || last_grant == PORT_I)) begin
            return PORT_D;
        end
        return PORT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between a memory client and a memory server.
// The same shape is used for the I port, the D port and the mem_system side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              stall;
    logic              cachehit;
    logic              err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, done, stall, cachehit, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, done, stall, cachehit, err
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Busy-cycle counter: cleared outside a transaction, counts cycles without
// completion and flags the last permitted cycle.
module mem_arbiter_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between a read-only instruction port and a data port,
// routing completion back to the granted port and aborting hung transactions.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no transaction; arbitrate I vs D requests
//   ST_BUSY    | latched request driven to mem_system until m_done or timeout
//   ST_ABORT   | watchdog fired; owner gets done+err, memory request dropped
//   ST_ILLEGAL | D asked for read and write at once; D gets done+err
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 64,
    parameter int TO_W      = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  i_port,
    mem_arbiter_if.slave  d_port,
    mem_arbiter_if.master m_port
);

    arb_state_t        state_q;
    port_t             owner_q;
    port_t             last_grant_q;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic  i_req;
    logic  d_req;
    logic  d_illegal;
    logic  busy;
    logic  finish;
    logic  ended;
    logic  failed;
    logic  own_d;
    logic  wd_expire;
    port_t grant;

    assign i_req     = i_port.rd;
    assign d_req     = d_port.rd | d_port.wr;
    assign d_illegal = d_port.rd & d_port.wr;
    assign grant     = pick_port(i_req, d_req, PRIO_MODE != 0, last_grant_q);

    assign busy   = (state_q == ST_BUSY);
    assign finish = busy & m_port.done;

    mem_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (~busy),
        .en_i     (busy & ~m_port.done),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_I;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (d_illegal) begin
                        state_q <= ST_ILLEGAL;
                        owner_q <= PORT_D;
                    end else if (i_req || d_req) begin
                        state_q      <= ST_BUSY;
                        owner_q      <= grant;
                        last_grant_q <= grant;
                        if (grant == PORT_D) begin
                            addr_q  <= d_port.addr;
                            wdata_q <= d_port.data_in;
                            op_q    <= d_port.wr ? OP_WR : OP_RD;
                        end else begin
                            addr_q  <= i_port.addr;
                            wdata_q <= '0;
                            op_q    <= OP_RD;
                        end
                    end
                end
                ST_BUSY: begin
                    // Completion wins over a watchdog hit on the same cycle.
                    if (m_port.done) begin
                        state_q <= ST_IDLE;
                    end else if (wd_expire) begin
                        state_q <= ST_ABORT;
                    end
                end
                ST_ABORT:   state_q <= ST_IDLE;
                ST_ILLEGAL: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign own_d  = (owner_q == PORT_D);
    assign ended  = finish | (state_q == ST_ABORT);
    assign failed = (state_q == ST_ABORT) | (state_q == ST_ILLEGAL);

    assign i_port.done     = ended & ~own_d;
    assign i_port.err      = i_port.done & (failed | m_port.err);
    assign i_port.cachehit = finish & ~own_d & m_port.cachehit;
    assign i_port.data_out = (finish & ~own_d) ? m_port.data_out : '0;
    assign i_port.stall    = i_req & ~i_port.done;

    assign d_port.done     = (ended & own_d) | (state_q == ST_ILLEGAL);
    assign d_port.err      = d_port.done & (failed | m_port.err);
    assign d_port.cachehit = finish & own_d & m_port.cachehit;
    assign d_port.data_out = (finish & own_d) ? m_port.data_out : '0;
    assign d_port.stall    = d_req & ~d_port.done;

    assign m_port.rd      = busy & (op_q == OP_RD);
    assign m_port.wr      = busy & (op_q == OP_WR);
    assign m_port.addr    = addr_q;
    assign m_port.data_in = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share one
// set of stimulus; directed rows, a reset-in-flight sequence and random rounds.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_addr = '0;
    logic        i_rd = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] m_rdata = '0;
    logic        m_done = 1'b0;
    logic        m_hit = 1'b0;
    logic        m_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if ia_i ();
    mem_arbiter_if ia_d ();
    mem_arbiter_if ia_m ();
    mem_arbiter_if ib_i ();
    mem_arbiter_if ib_d ();
    mem_arbiter_if ib_m ();

    assign ia_i.addr = i_addr;    assign ib_i.addr = i_addr;
    assign ia_i.rd = i_rd;        assign ib_i.rd = i_rd;
    assign ia_i.wr = 1'b0;        assign ib_i.wr = 1'b0;
    assign ia_i.data_in = '0;     assign ib_i.data_in = '0;
    assign ia_d.addr = d_addr;    assign ib_d.addr = d_addr;
    assign ia_d.data_in = d_wdata; assign ib_d.data_in = d_wdata;
    assign ia_d.rd = d_rd;        assign ib_d.rd = d_rd;
    assign ia_d.wr = d_wr;        assign ib_d.wr = d_wr;
    assign ia_m.data_out = m_rdata; assign ib_m.data_out = m_rdata;
    assign ia_m.done = m_done;    assign ib_m.done = m_done;
    assign ia_m.cachehit = m_hit; assign ib_m.cachehit = m_hit;
    assign ia_m.err = m_err;      assign ib_m.err = m_err;
    assign ia_m.stall = 1'b0;     assign ib_m.stall = 1'b0;

    mem_arbiter #(.PRIO_MODE(0), .TIMEOUT(TO), .TO_W(4)) u_dut_rr (
        .clk_i (clk), .rst_i (rst), .i_port (ia_i), .d_port (ia_d), .m_port (ia_m)
    );

    mem_arbiter #(.PRIO_MODE(1), .TIMEOUT(TO), .TO_W(4)) u_dut_fp (
        .clk_i (clk), .rst_i (rst), .i_port (ib_i), .d_port (ib_d), .m_port (ib_m)
    );

    typedef struct packed {
        logic i_done, i_err, i_hit, i_stall;
        logic d_done, d_err, d_hit, d_stall;
        logic m_rd, m_wr;
    } st_t;

    // own: 0 = I served, 1 = D served, 2 = D illegal request
    typedef struct {
        string       name;
        int          sel;
        logic        i_rd;
        logic [15:0] i_addr;
        logic        d_rd, d_wr;
        logic [15:0] d_addr, d_wdata;
        int          lat;
        logic [15:0] mdata;
        logic        mhit, merr;
        int          own, cyc;
        logic        eerr, ehit;
        logic [15:0] edata;
    } txn_t;

    function automatic txn_t mk(input string name, input int sel,
                                input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw,
                                input logic [15:0] da, input logic [15:0] dd,
                                input int lat, input logic [15:0] md,
                                input logic mh, input logic me,
                                input int own, input int cyc, input logic ee,
                                input logic eh, input logic [15:0] ed);
        txn_t t;
        t.name = name; t.sel = sel; t.i_rd = ir; t.i_addr = ia;
        t.d_rd = dr; t.d_wr = dw; t.d_addr = da; t.d_wdata = dd;
        t.lat = lat; t.mdata = md; t.mhit = mh; t.merr = me;
        t.own = own; t.cyc = cyc; t.eerr = ee; t.ehit = eh; t.edata = ed;
        return t;
    endfunction

    function automatic st_t get_st(input int sel);
        st_t s;
        if (sel == 0)
            s = {ia_i.done, ia_i.err, ia_i.cachehit, ia_i.stall,
                 ia_d.done, ia_d.err, ia_d.cachehit, ia_d.stall, ia_m.rd, ia_m.wr};
        else
            s = {ib_i.done, ib_i.err, ib_i.cachehit, ib_i.stall,
                 ib_d.done, ib_d.err, ib_d.cachehit, ib_d.stall, ib_m.rd, ib_m.wr};
        return s;
    endfunction

    function automatic logic [15:0] get_idata(input int sel);
        return (sel == 0) ? ia_i.data_out : ib_i.data_out;
    endfunction
    function automatic logic [15:0] get_ddata(input int sel);
        return (sel == 0) ? ia_d.data_out : ib_d.data_out;
    endfunction
    function automatic logic [15:0] get_maddr(input int sel);
        return (sel == 0) ? ia_m.addr : ib_m.addr;
    endfunction
    function automatic logic [15:0] get_mwdata(input int sel);
        return (sel == 0) ? ia_m.data_in : ib_m.data_in;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_rd = 0; d_rd = 0; d_wr = 0; m_done = 0; m_hit = 0; m_err = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One request round from the IDLE cycle (c=0) through the completion cycle,
    // followed by an idle cycle with a stray m_done that must be ignored.
    task automatic run_txn(input txn_t t);
        st_t  e;
        bit   busy, dn, seen;
        seen = 0;
        @(posedge clk); #1;
        i_rd = t.i_rd; i_addr = t.i_addr;
        d_rd = t.d_rd; d_wr = t.d_wr; d_addr = t.d_addr; d_wdata = t.d_wdata;
        m_done = 0; m_rdata = 16'($urandom); m_hit = 0; m_err = 0;
        for (int c = 0; c <= TO + 3; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                m_done  = (c == t.lat);
                m_rdata = (c == t.lat) ? t.mdata : 16'($urandom);
                m_hit   = (c == t.lat) ? t.mhit : 1'($urandom);
                m_err   = (c == t.lat) ? t.merr : 1'($urandom);
            end
            @(negedge clk);
            dn   = (c == t.cyc);
            busy = (t.own != 2) && (c >= 1) && ((c < t.cyc) || (dn && t.cyc <= TO));
            e = '0;
            e.i_done  = dn && (t.own == 0);
            e.d_done  = dn && (t.own != 0);
            e.i_err   = e.i_done & t.eerr;
            e.d_err   = e.d_done & t.eerr;
            e.i_hit   = e.i_done & t.ehit;
            e.d_hit   = e.d_done & t.ehit;
            e.i_stall = t.i_rd & ~e.i_done;
            e.d_stall = (t.d_rd | t.d_wr) & ~e.d_done;
            e.m_rd    = busy && ((t.own == 0) || t.d_rd);
            e.m_wr    = busy && (t.own == 1) && t.d_wr;
            chk($sformatf("%s c%0d status", t.name, c), 32'(get_st(t.sel)), 32'(e));
            if (busy) begin
                chk($sformatf("%s c%0d m_addr", t.name, c), 32'(get_maddr(t.sel)),
                    32'((t.own == 0) ? t.i_addr : t.d_addr));
                if (t.own == 1)
                    chk($sformatf("%s c%0d m_data_in", t.name, c),
                        32'(get_mwdata(t.sel)), 32'(t.d_wdata));
            end
            if (dn) begin
                chk($sformatf("%s data_out", t.name),
                    32'((t.own == 0) ? get_idata(t.sel) : get_ddata(t.sel)), 32'(t.edata));
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL %s: no completion within %0d cycles", t.name, TO + 3);
        end
        @(posedge clk); #1;
        i_rd = 0; d_rd = 0; d_wr = 0;
        m_done = 1; m_rdata = 16'($urandom); m_hit = 1; m_err = 1;
        @(negedge clk);
        chk($sformatf("%s idle", t.name), 32'(get_st(t.sel)), 32'(0));
    endtask

    txn_t tbl[$];

    initial begin
        #300000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        txn_t t;
        int   prev_sel;
        int   mdl_last;
        int   dk;

        tbl.push_back(mk("tie_d_first",   0, 1, 16'h0040, 1, 0, 16'h0200, 16'h0000, 2, 16'hBEEF, 1, 0, 1, 2, 0, 1, 16'hBEEF));
        tbl.push_back(mk("tie_i_next",    0, 1, 16'h0040, 0, 1, 16'h0300, 16'h5555, 1, 16'h1111, 0, 1, 0, 1, 1, 0, 16'h1111));
        tbl.push_back(mk("tie_d_again",   0, 1, 16'h0040, 0, 1, 16'h0300, 16'h5555, 4, 16'h2222, 1, 0, 1, 4, 0, 1, 16'h2222));
        tbl.push_back(mk("i_alone",       0, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 3, 16'hCAFE, 1, 0, 0, 3, 0, 1, 16'hCAFE));
        tbl.push_back(mk("d_illegal",     0, 0, 16'h0000, 1, 1, 16'h0400, 16'h0000, 0, 16'h0000, 0, 0, 2, 1, 1, 0, 16'h0000));
        tbl.push_back(mk("d_timeout",     0, 0, 16'h0000, 1, 0, 16'h0AAA, 16'h0000, 0, 16'h0000, 0, 0, 1, TO + 1, 1, 0, 16'h0000));
        tbl.push_back(mk("i_last_cycle",  0, 1, 16'h0800, 0, 0, 16'h0000, 16'h0000, TO, 16'h7777, 0, 0, 0, TO, 0, 0, 16'h7777));
        tbl.push_back(mk("d_done_late",   0, 0, 16'h0000, 0, 1, 16'h0900, 16'hA5A5, TO + 1, 16'h9999, 1, 0, 1, TO + 1, 1, 0, 16'h0000));
        tbl.push_back(mk("illegal_with_i",0, 1, 16'h0010, 1, 1, 16'h0020, 16'h0000, 0, 16'h0000, 0, 0, 2, 1, 1, 0, 16'h0000));
        tbl.push_back(mk("fp_d_wr_1",     1, 1, 16'h0040, 0, 1, 16'h0102, 16'h1234, 2, 16'h00F0, 0, 0, 1, 2, 0, 0, 16'h00F0));
        tbl.push_back(mk("fp_d_wr_2",     1, 1, 16'h0040, 0, 1, 16'h0102, 16'h1234, 2, 16'h00F1, 0, 0, 1, 2, 0, 0, 16'h00F1));
        tbl.push_back(mk("fp_d_wr_3",     1, 1, 16'h0040, 0, 1, 16'h0102, 16'h1234, 2, 16'h00F2, 0, 0, 1, 2, 0, 0, 16'h00F2));
        tbl.push_back(mk("fp_i_after",    1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 16'h3C3C, 1, 0, 0, 1, 0, 1, 16'h3C3C));

        do_reset();
        @(negedge clk);
        chk("reset status rr", 32'(get_st(0)), 32'(0));
        chk("reset status fp", 32'(get_st(1)), 32'(0));
        chk("reset m_addr rr", 32'(get_maddr(0)), 32'(0));
        chk("reset m_data_in fp", 32'(get_mwdata(1)), 32'(0));

        prev_sel = 0;
        foreach (tbl[k]) begin
            if (tbl[k].sel != prev_sel) begin
                do_reset();
                prev_sel = tbl[k].sel;
            end
            run_txn(tbl[k]);
        end

        // Reset while D owns the memory: no done pulse, outputs cleared,
        // and arbitration history back to its reset value.
        do_reset();
        @(posedge clk); #1;
        d_rd = 1; d_wr = 0; d_addr = 16'h0123; d_wdata = 16'h0456; i_rd = 0; m_done = 0;
        @(posedge clk); #1;
        @(negedge clk);
        t = mk("x", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_busy pre status", 32'(get_st(0)), 32'(10'b0000_0001_10));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; d_rd = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_busy status %0d", c), 32'(get_st(0)), 32'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_busy m_addr", 32'(get_maddr(0)), 32'(0));
        chk("rst_busy m_data_in", 32'(get_mwdata(0)), 32'(0));
        run_txn(mk("post_rst_tie", 0, 1, 16'h0050, 1, 0, 16'h0060, 16'h0000, 1, 16'h4242, 0, 0, 1, 1, 0, 0, 16'h4242));

        // Random rounds against a transaction-level model of the round-robin unit.
        do_reset();
        mdl_last = 0;
        for (int r = 0; r < 40; r++) begin
            t = mk($sformatf("rnd%0d", r), 0, 1'($urandom), 16'($urandom), 0, 0,
                   16'($urandom), 16'($urandom), $urandom_range(1, TO + 3),
                   16'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0);
            dk = $urandom_range(0, 9);
            t.d_rd = (dk == 0) || (dk >= 1 && dk <= 3);
            t.d_wr = (dk == 0) || (dk >= 4 && dk <= 6);
            if (!t.i_rd && !t.d_rd && !t.d_wr) t.i_rd = 1;
            if (t.d_rd && t.d_wr) begin
                t.own = 2; t.cyc = 1; t.eerr = 1; t.ehit = 0; t.edata = 0;
            end else begin
                if (t.i_rd && (t.d_rd || t.d_wr)) t.own = (mdl_last == 0) ? 1 : 0;
                else                             t.own = (t.d_rd || t.d_wr) ? 1 : 0;
                mdl_last = t.own;
                if (t.lat <= TO) begin
                    t.cyc = t.lat; t.eerr = t.merr; t.ehit = t.mhit; t.edata = t.mdata;
                end else begin
                    t.cyc = TO + 1; t.eerr = 1; t.ehit = 0; t.edata = 0;
                end
            end
            run_txn(t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
